// File: rtl/frv_exec_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : frv_exec_result_queue
// Description : Multi-entry result queue between execute and writeback.
//               Circular buffer of DEPTH entries {rd, wdata, load, payload}
//               with a youngest-match register-forwarding lookup across all
//               occupied entries.
// Optional    : FRV_RESULT_QUEUE_BYPASS_EN - when the queue is empty an
//               offered result is presented on o_* in the same cycle and,
//               if writeback accepts it, is never stored.
// Ports       : g_clk/g_reset   clock, asynchronous active-high reset
//               flush           discard all entries on the next edge
//               i_valid/o_busy  execute-side handshake (o_busy = full)
//               i_rd/i_wdata/i_load/i_payload   offered result
//               o_valid/i_busy  writeback-side handshake
//               o_rd/o_wdata/o_load/o_payload   head entry
//               fwd_rs -> fwd_hit/fwd_wdata/fwd_load   forwarding lookup
//               count           occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
module frv_exec_result_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PW    = 48,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            i_valid,
    output logic            o_busy,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_load,
    input  logic [PW-1:0]   i_payload,
    output logic            o_valid,
    input  logic            i_busy,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_load,
    output logic [PW-1:0]   o_payload,
    input  logic [4:0]      fwd_rs,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_wdata,
    output logic            fwd_load,
    output logic [CW-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    // Entry storage
    logic [4:0]      r_rd      [DEPTH];
    logic [XLEN-1:0] r_wdata   [DEPTH];
    logic            r_load    [DEPTH];
    logic [PW-1:0]   r_payload [DEPTH];

    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_bypass;   // input presented directly on o_*
    logic            w_direct;   // input consumed by writeback, never stored
    logic            w_push;
    logic            w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

`ifdef FRV_RESULT_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && i_valid;
    assign w_direct = w_bypass && !i_busy && !flush;
`else
    assign w_bypass = 1'b0;
    assign w_direct = 1'b0;
`endif

    // Full-queue check uses the registered count only, so a same-cycle pop
    // never opens a slot and there is no combinational i_busy -> o_busy path.
    assign w_push = i_valid && !w_full && !w_direct && !flush;
    assign w_pop  = !w_empty && !i_busy && !flush;

    assign o_busy  = w_full;
    assign o_valid = !w_empty || w_bypass;
    assign count   = r_count;

    assign o_rd      = w_bypass ? i_rd      : r_rd[r_rptr];
    assign o_wdata   = w_bypass ? i_wdata   : r_wdata[r_rptr];
    assign o_load    = w_bypass ? i_load    : r_load[r_rptr];
    assign o_payload = w_bypass ? i_payload : r_payload[r_rptr];

    // Forwarding: walk occupied entries oldest to youngest so that the last
    // match written wins (youngest-match priority).
    logic [AW-1:0]   w_fidx;
    logic            w_fwd_hit;
    logic [XLEN-1:0] w_fwd_wdata;
    logic            w_fwd_load;

    always_comb begin
        w_fidx      = r_rptr;
        w_fwd_hit   = 1'b0;
        w_fwd_wdata = '0;
        w_fwd_load  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fidx = r_rptr + AW'(i);
            if ((CW'(i) < r_count) && (fwd_rs != 5'd0) && (r_rd[w_fidx] == fwd_rs)) begin
                w_fwd_hit   = 1'b1;
                w_fwd_wdata = r_wdata[w_fidx];
                w_fwd_load  = r_load[w_fidx];
            end
        end
    end

    assign fwd_hit   = w_fwd_hit;
    assign fwd_wdata = w_fwd_wdata;
    assign fwd_load  = w_fwd_load;

    // Pointers and occupancy
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage; flush leaves contents in place, only reset clears them.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]      <= '0;
                r_wdata[i]   <= '0;
                r_load[i]    <= 1'b0;
                r_payload[i] <= '0;
            end
        end else if (w_push) begin
            r_rd[r_wptr]      <= i_rd;
            r_wdata[r_wptr]   <= i_wdata;
            r_load[r_wptr]    <= i_load;
            r_payload[r_wptr] <= i_payload;
        end
    end

endmodule
`default_nettype wire

// File: doc/frv_exec_result_queue.md
# frv_exec_result_queue

Parametrised multi-entry result queue between the execute and writeback stages, successor to the single-entry execute pipeline register. It buffers up to DEPTH completed execute results so that writeback stalls do not immediately back-pressure execute. It also provides a youngest-match register-forwarding lookup across all buffered entries. Optionally, when empty, it passes a result straight through with zero latency.

## Interface

Parameters:
- XLEN, 32: result data width.
- DEPTH, 4: number of entries; power of two, ≥2.
- PW, 48: width of the opaque payload (uop, fu, trap, size, instr, …) carried alongside each result.

Ports (CW = $clog2(DEPTH+1)):
- g_clk  in  1  global clock; all state updates on the rising edge.
- g_reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries.
- i_valid  in  1  an execute result is offered.
- o_busy  out  1  queue cannot accept (full).
- i_rd  in  5  destination register of the offered result.
- i_wdata  in  XLEN  result data.
- i_load  in  1  result is a load; its data is not yet final.
- i_payload  in  PW  opaque sideband.
- o_valid  out  1  head entry valid.
- i_busy  in  1  writeback cannot accept.
- o_rd  out  5  head destination register.
- o_wdata  out  XLEN  head data.
- o_load  out  1  head load flag.
- o_payload  out  PW  head sideband.
- fwd_rs  in  5  source register to look up.
- fwd_hit  out  1  a buffered entry writes fwd_rs.
- fwd_wdata  out  XLEN  data of the youngest matching entry.
- fwd_load  out  1  youngest match is a load; the consumer must stall.
- count  out  CW  number of occupied entries.

## Operation

- Storage is a circular buffer of DEPTH entries {rd, wdata, load, payload}, with a write pointer and a read pointer, each $clog2(DEPTH) bits, plus a CW-bit occupancy counter.
- Push: i_valid && !o_busy. The entry is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: o_valid && !i_busy. The read pointer increments modulo DEPTH.
- count is updated as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- o_busy = (count == DEPTH). It never depends on i_busy, so there is no combinational busy path. When the queue is full, a same-cycle pop does not enable a push.
- o_valid = (count != 0). The o_* fields are read combinationally from the entry at the read pointer.
- Flush:
  - On the next edge, count, the read pointer and the write pointer all go to 0.
  - Any push or pop in the flush cycle is ignored.
  - Stored data is not cleared.
- Forwarding (combinational):
  - Scan the occupied entries only.
  - The youngest entry (closest to the write pointer) with rd == fwd_rs wins.
  - fwd_rs == 0 never hits.
  - On a miss: fwd_hit = 0, fwd_wdata = 0, fwd_load = 0.
  - The entry being pushed this cycle is not searched.
- Reset: count, both pointers and all storage go to 0. Consequently, after reset:
  - o_valid = 0, o_busy = 0.
  - o_rd, o_wdata, o_load, o_payload are all 0.
  - fwd_hit = 0, count = 0.

## Timing

- Without bypass, push-to-o_valid latency is 1 cycle.
- Sustained throughput is 1 push and 1 pop per cycle.
- A full queue accepts again in the cycle after a pop (o_busy drops one edge later).
- A flush asserted in cycle N gives o_valid = 0 and o_busy = 0 from cycle N+1.
- Reset asserted mid-operation forces the reset state immediately, without waiting for a clock edge.
- The pointers wrap from DEPTH−1 to 0 with no bubble.

## Configuration

- FRV_RESULT_QUEUE_BYPASS_EN defined:
  - When count == 0 and i_valid, the queue passes the input straight to the output: o_valid = 1 and o_* = i_*.
  - If additionally !i_busy and !flush, the result is consumed by writeback directly. No entry is written and count stays 0 (zero latency).
  - If i_busy is high in that case, the entry is pushed normally.
  - Forwarding is unaffected.
- FRV_RESULT_QUEUE_BYPASS_EN undefined: every result is stored, with a minimum latency of 1 cycle.

## Test plan

- Reset: assert g_reset mid-stream with count = 3 -> all outputs 0 immediately; count = 0 after reset is released.
- Fill/drain: with i_busy = 1, push rd = 1..4 with wdata 0x11..0x44 (DEPTH = 4) -> o_busy = 1 after the 4th push and a 5th offer is not accepted. Then release i_busy -> entries pop in order 0x11, 0x22, 0x33, 0x44, and o_valid = 0 after the last.
- Wrap and concurrency: keep count = 2 while pushing and popping every cycle for 10 cycles -> data stays in order across the pointer wrap and count holds at 2.
- Forwarding: buffer rd = 5/0xA (oldest), rd = 5/0xB with load = 1, and rd = 0/0xC. Then:
  - fwd_rs = 5 -> fwd_hit = 1, fwd_wdata = 0xB, fwd_load = 1.
  - fwd_rs = 0 -> fwd_hit = 0.
- Flush: flush with count = 3 while a push is offered -> next cycle count = 0 and o_valid = 0, and the offered push is lost.
- Bypass (with FRV_RESULT_QUEUE_BYPASS_EN): queue empty, i_valid with wdata = 0x55, i_busy = 0 -> o_wdata = 0x55 in the same cycle and count remains 0. Repeat with i_busy = 1 -> count = 1 on the next cycle.
